// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
// Shares the single register-file write port and the scoreboard pending-clear
// path among the three functional units fed by Issue: ALU (code 01), MEM (10)
// and MUL (11). Round-robin arbitration with a starvation override. The winning
// item is registered and presented one cycle after acceptance. A saturating
// counter records cycles in which two or more units compete.
//
// Ports:
//   clock           system clock, all state on rising edge
//   reset           asynchronous active-high reset, clears all state
//   flush           synchronous flush (contention counter is kept)
//   fu_valid[2:0]   per-unit request (bit0 ALU, bit1 MEM, bit2 MUL)
//   fu_ready[2:0]   per-unit grant, combinational, one-hot or zero
//   fu_regdest      destination register per unit, slice i = [i*ADDR_W +: ADDR_W]
//   fu_data         result per unit, slice i = [i*DATA_W +: DATA_W]
//   fu_writereg     unit result writes a register
//   fu_writeov      overflow-conditional write flag per unit
//   wb_we/wb_addr/wb_data/wb_writeov   register-file write port
//   sb_clr/sb_clr_addr/sb_clr_fu       scoreboard pending-clear path
//   contention_cnt  saturating count of cycles with >= 2 valid requesters
// -----------------------------------------------------------------------------
module wb_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                flush,
    input  logic [2:0]          fu_valid,
    output logic [2:0]          fu_ready,
    input  logic [3*ADDR_W-1:0] fu_regdest,
    input  logic [3*DATA_W-1:0] fu_data,
    input  logic [2:0]          fu_writereg,
    input  logic [2:0]          fu_writeov,
    output logic                wb_we,
    output logic [ADDR_W-1:0]   wb_addr,
    output logic [DATA_W-1:0]   wb_data,
    output logic                wb_writeov,
    output logic                sb_clr,
    output logic [ADDR_W-1:0]   sb_clr_addr,
    output logic [1:0]          sb_clr_fu,
    output logic [CNT_W-1:0]    contention_cnt
);

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    logic [1:0] ptr;
    logic [1:0] ptr_next;
    logic [3:0] wait_cnt [3];
    logic [2:0] starving;
    logic [2:0] grant;
    logic [1:0] grant_idx;
    logic       transfer;
    logic       contention;

    logic [ADDR_W-1:0] sel_regdest;
    logic [DATA_W-1:0] sel_data;
    logic              sel_writereg;
    logic              sel_writeov;

    // Grant selection: starving units win (lowest index first), otherwise
    // search upward from the round-robin pointer. Reset and flush block grants.
    always_comb begin
        grant = 3'b000;
        for (int i = 0; i < 3; i++) begin
            starving[i] = fu_valid[i] && (wait_cnt[i] == WAIT_LIMIT);
        end
        if (!reset && !flush) begin
            if (starving[0])      grant = 3'b001;
            else if (starving[1]) grant = 3'b010;
            else if (starving[2]) grant = 3'b100;
            else begin
                case (ptr)
                    2'd1: begin
                        if (fu_valid[1])      grant = 3'b010;
                        else if (fu_valid[2]) grant = 3'b100;
                        else if (fu_valid[0]) grant = 3'b001;
                    end
                    2'd2: begin
                        if (fu_valid[2])      grant = 3'b100;
                        else if (fu_valid[0]) grant = 3'b001;
                        else if (fu_valid[1]) grant = 3'b010;
                    end
                    default: begin
                        if (fu_valid[0])      grant = 3'b001;
                        else if (fu_valid[1]) grant = 3'b010;
                        else if (fu_valid[2]) grant = 3'b100;
                    end
                endcase
            end
        end
    end

    assign fu_ready = grant;
    assign transfer = |grant;

    // Encode the one-hot grant and steer the winning unit's item.
    always_comb begin
        grant_idx = 2'd0;
        if (grant[1])      grant_idx = 2'd1;
        else if (grant[2]) grant_idx = 2'd2;
        sel_regdest  = fu_regdest[grant_idx*ADDR_W +: ADDR_W];
        sel_data     = fu_data[grant_idx*DATA_W +: DATA_W];
        sel_writereg = fu_writereg[grant_idx];
        sel_writeov  = fu_writeov[grant_idx];
        ptr_next     = ptr;
        if (transfer) ptr_next = (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;
    end

    assign contention = (fu_valid[0] & fu_valid[1]) |
                        (fu_valid[0] & fu_valid[2]) |
                        (fu_valid[1] & fu_valid[2]);

    // Pointer, wait counters and the registered output stage. Outputs are a
    // one-cycle pulse per transfer; flush returns everything to reset values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr         <= 2'd0;
            wait_cnt    <= '{default: 4'd0};
            wb_we       <= 1'b0;
            wb_addr     <= '0;
            wb_data     <= '0;
            wb_writeov  <= 1'b0;
            sb_clr      <= 1'b0;
            sb_clr_addr <= '0;
            sb_clr_fu   <= 2'd0;
        end else if (flush) begin
            ptr         <= 2'd0;
            wait_cnt    <= '{default: 4'd0};
            wb_we       <= 1'b0;
            wb_addr     <= '0;
            wb_data     <= '0;
            wb_writeov  <= 1'b0;
            sb_clr      <= 1'b0;
            sb_clr_addr <= '0;
            sb_clr_fu   <= 2'd0;
        end else begin
            ptr <= ptr_next;
            for (int i = 0; i < 3; i++) begin
                if (!fu_valid[i] || grant[i])     wait_cnt[i] <= 4'd0;
                else if (wait_cnt[i] < WAIT_LIMIT) wait_cnt[i] <= wait_cnt[i] + 4'd1;
            end
            if (transfer) begin
                wb_we       <= sel_writereg && (sel_regdest != '0);
                wb_addr     <= sel_regdest;
                wb_data     <= sel_data;
                wb_writeov  <= sel_writeov;
                sb_clr      <= sel_writereg;
                sb_clr_addr <= sel_regdest;
                sb_clr_fu   <= grant_idx + 2'd1;
            end else begin
                wb_we       <= 1'b0;
                wb_addr     <= '0;
                wb_data     <= '0;
                wb_writeov  <= 1'b0;
                sb_clr      <= 1'b0;
                sb_clr_addr <= '0;
                sb_clr_fu   <= 2'd0;
            end
        end
    end

    // Contention counter survives flush and saturates instead of wrapping.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            contention_cnt <= '0;
        end else if (contention && (contention_cnt != '1)) begin
            contention_cnt <= contention_cnt + 1'b1;
        end
    end

endmodule
